// File: rtl/sum_uart_tx_pkg.sv
// sum_tx_pkg: shared types and sizing helpers for the sum UART transmitter.
package sum_tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int UART_FRAME_BITS = 10;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/sum_uart_tx_if.sv
// sum_uart_tx_if: trigger, payload and serial/status signals of the sum UART transmitter.
interface sum_uart_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic send;
  logic clr_ovr;
  logic tx;
  logic busy;
  logic done;
  logic overrun;
  modport master (output data_in, send, clr_ovr, input tx, busy, done, overrun);
  modport slave (input data_in, send, clr_ovr, output tx, busy, done, overrun);
endinterface

// File: rtl/sum_uart_tx_sync_rise.sv
// sync_rise: 2-FF synchroniser plus delay flop; rise is high for one cycle per low->high input edge.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= '0;
    else s_q <= s_d;
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: sends the adder sum as one 8N1 UART frame per rising edge of send.
module sum_uart_tx
  import sum_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  sum_uart_tx_if.slave bus
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be in 2..65535");
  end
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic rise, wrap;
  sync_rise u_sync (.clk(clk), .rst_n(rst_n), .in(bus.send), .rise(rise));
  assign wrap = cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  // A rise during the done cycle still counts as busy and is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    case (state_q)
      IDLE: if (rise && !done_q) begin
        state_d = START;
        sh_d = bus.data_in;
      end
      START: if (wrap) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (wrap) begin
        state_d = (idx_q == BLAST) ? STOP : DATA;
        idx_d = idx_q + 1'b1;
        sh_d = sh_q >> 1;
      end
      STOP: if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && state_d == IDLE;
    ovr_d = (rise && (state_q != IDLE || done_q)) || (ovr_q && !bus.clr_ovr);
  end
  assign bus.tx = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: directed scoreboard bench for sum_uart_tx at CLKS_PER_BIT 4 and 2.
module tb_sum_uart_tx;
  import sum_tx_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sum_uart_tx_if if4 ();
  sum_uart_tx_if if2 ();
  sum_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  sum_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  int checks = 0;
  int errors = 0;
  int dsel = 0;
  int dn4 = 0;
  int dn2 = 0;
  int d0;
  int bad;
  logic [7:0] sb[$];
  wire tx_m = (dsel != 0) ? if2.tx : if4.tx;
  wire busy_m = (dsel != 0) ? if2.busy : if4.busy;
  wire done_m = (dsel != 0) ? if2.done : if4.done;
  wire ovr_m = (dsel != 0) ? if2.overrun : if4.overrun;
  always @(negedge clk) begin
    if (if4.done === 1'b1) dn4++;
    if (if2.done === 1'b1) dn2++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_send(input logic v);
    if (dsel != 0) if2.send = v;
    else if4.send = v;
  endtask
  task automatic start(input logic [7:0] d);
    if (dsel != 0) if2.data_in = d;
    else if4.data_in = d;
    sb.push_back(d);
    set_send(1'b1);
  endtask
  // Called right after the negedge where send went high; checks the whole frame.
  task automatic frame(input int c, input bit drop);
    logic [7:0] b;
    logic e;
    int bi;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (drop) set_send(1'b0);
    chk("pre_tx", tx_m, 1);
    chk("pre_busy", busy_m, 0);
    chk("sb_ready", sb.size(), 1);
    b = sb.pop_front();
    @(posedge clk);
    for (int i = 0; i < UART_FRAME_BITS * c; i++) begin
      @(negedge clk);
      bi = i / c;
      e = (bi == 0) ? 1'b0 : (bi == UART_FRAME_BITS - 1) ? 1'b1 : b[bi-1];
      chk("tx_bit", tx_m, e);
      chk("busy_in", busy_m, 1);
      chk("done_in", done_m, 0);
    end
  endtask
  task automatic tail();
    @(negedge clk);
    chk("done_pulse", done_m, 1);
    chk("busy_fall", busy_m, 0);
    chk("tx_idle", tx_m, 1);
    @(negedge clk);
    chk("done_once", done_m, 0);
  endtask
  initial begin
    if4.send = 0; if4.data_in = 0; if4.clr_ovr = 0;
    if2.send = 0; if2.data_in = 0; if2.clr_ovr = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      dsel = d;
      #1;
      chk("rst_tx", tx_m, 1);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_ovr", ovr_m, 0);
    end
    dsel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // single frame A5, payload input changed after accept
    start(8'hA5);
    fork
      frame(4, 1);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        if4.data_in = 8'h00;
      end
    join
    tail();
    chk("a5_ovr", ovr_m, 0);
    // overrun set, sticky, cleared
    repeat (3) @(negedge clk);
    start(8'h3C);
    fork
      frame(4, 1);
      begin
        repeat (12) @(negedge clk);
        if4.send = 1'b1;
        repeat (2) @(negedge clk);
        if4.send = 1'b0;
      end
    join
    tail();
    chk("ovr_set", ovr_m, 1);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", ovr_m, 1);
    if4.clr_ovr = 1'b1;
    @(negedge clk);
    if4.clr_ovr = 1'b0;
    chk("ovr_clr", ovr_m, 0);
    // clear and new overrun in the same cycle
    repeat (3) @(negedge clk);
    start(8'h5A);
    fork
      frame(4, 1);
      begin
        repeat (10) @(negedge clk);
        if4.send = 1'b1;
        repeat (2) @(negedge clk);
        if4.clr_ovr = 1'b1;
        if4.send = 1'b0;
        @(negedge clk);
        if4.clr_ovr = 1'b0;
        chk("ovr_set_wins", ovr_m, 1);
      end
    join
    tail();
    if4.clr_ovr = 1'b1;
    @(negedge clk);
    if4.clr_ovr = 1'b0;
    chk("ovr_clr2", ovr_m, 0);
    // back-to-back: second edge lands the cycle after done
    repeat (3) @(negedge clk);
    d0 = dn4;
    start(8'hFF);
    frame(4, 1);
    start(8'h01);
    fork
      frame(4, 1);
      tail();
    join
    tail();
    chk("b2b_done_cnt", dn4 - d0, 2);
    chk("b2b_ovr", ovr_m, 0);
    // reset mid-DATA with overrun set
    repeat (3) @(negedge clk);
    if4.data_in = 8'h81;
    if4.send = 1'b1;
    repeat (2) @(negedge clk);
    if4.send = 1'b0;
    repeat (4) @(negedge clk);
    if4.send = 1'b1;
    repeat (2) @(negedge clk);
    if4.send = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_pre_busy", busy_m, 1);
    chk("rst_pre_ovr", ovr_m, 1);
    chk("rst_pre_tx", tx_m, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_m, 1);
    chk("mid_rst_busy", busy_m, 0);
    chk("mid_rst_done", done_m, 0);
    chk("mid_rst_ovr", ovr_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    // send held high at CLKS_PER_BIT=2: one frame only
    dsel = 1;
    repeat (3) @(negedge clk);
    d0 = dn2;
    start(8'hC3);
    frame(2, 0);
    tail();
    bad = 0;
    repeat (170) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
    end
    chk("held_one_frame", bad, 0);
    if2.send = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_done_cnt", dn2 - d0, 1);
    chk("held_busy", busy_m, 0);
    chk("held_ovr", ovr_m, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
